// File: rtl/ariane_ace.sv
// ACE snoop channel bundles (AC out, CR/CD in) between interconnect and dcache ports.
package ariane_ace;

    typedef struct packed {
        logic [63:0]          addr;
        snoop_pkg::acsnoop_t  snoop;
        logic [2:0]           prot;
    } ace_ac_chan_t;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } ace_cd_chan_t;

    typedef struct packed {
        logic         ac_valid;
        ace_ac_chan_t ac;
        logic         cr_ready;
        logic         cd_ready;
    } snoop_req_t;

    typedef struct packed {
        logic               ac_ready;
        logic               cr_valid;
        snoop_pkg::crresp_t cr_resp;
        logic               cd_valid;
        ace_cd_chan_t       cd;
    } snoop_resp_t;

endpackage

// File: rtl/snoop_pkg.sv
// Shared snoop types: AC snoop opcodes, CR response bits and the initiator FSM state.
// Also provides the lowest-set-index helper used to pick the data source port.
package snoop_pkg;

    typedef logic [3:0] acsnoop_t;

    localparam acsnoop_t READ_ONCE             = 4'h0;
    localparam acsnoop_t READ_SHARED           = 4'h1;
    localparam acsnoop_t READ_CLEAN            = 4'h2;
    localparam acsnoop_t READ_NOT_SHARED_DIRTY = 4'h3;
    localparam acsnoop_t READ_UNIQUE           = 4'h7;
    localparam acsnoop_t CLEAN_SHARED          = 4'h8;
    localparam acsnoop_t CLEAN_INVALID         = 4'h9;
    localparam acsnoop_t MAKE_INVALID          = 4'hD;

    typedef struct packed {
        logic wasUnique;
        logic isShared;
        logic passDirty;
        logic error;
        logic dataTransfer;
    } crresp_t;

    // Fields that are OR-merged across ports; wasUnique is not aggregated.
    localparam crresp_t CrMergeMask = 5'b01111;

    typedef enum logic [2:0] {
        IDLE,
        SEND_AC,
        WAIT_CR,
        RECV_CD,
        SEND_RESP
    } snoop_init_state_t;

    localparam int MaxPorts = 32;

    function automatic logic [4:0] lowest_set(input logic [MaxPorts-1:0] v);
        lowest_set = '0;
        for (int i = MaxPorts - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = 5'(i);
        end
    endfunction

endpackage

// File: rtl/snoop_port_tracker.sv
// Per-port snoop bookkeeping: target, AC/CR completion, CD pending and beat counter.
module snoop_port_tracker (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    input  logic target_i,
    input  logic ac_phase_i,
    input  logic cr_phase_i,
    input  logic cd_phase_i,
    input  logic timeout_i,
    input  logic ac_ready_i,
    input  logic cr_valid_i,
    input  logic cr_dt_i,
    input  logic cd_valid_i,
    input  logic cd_last_i,
    output logic target_o,
    output logic ac_valid_o,
    output logic cr_ready_o,
    output logic cd_ready_o,
    output logic ac_done_o,
    output logic cr_done_o,
    output logic cd_pend_o,
    output logic cr_fire_o,
    output logic cd_fire_o,
    output logic beat_o,
    output logic cd_bad_o
);

    logic tgt_q, ac_done_q, cr_done_q, cd_pend_q, beat_q;
    logic cd_end;

    assign ac_valid_o = ac_phase_i & tgt_q & ~ac_done_q;
    assign cr_ready_o = cr_phase_i & tgt_q & ~cr_done_q;
    assign cd_ready_o = cd_phase_i & cd_pend_q;
    assign cr_fire_o  = cr_ready_o & cr_valid_i;
    assign cd_fire_o  = cd_ready_o & cd_valid_i;

    // A beat closes the port when it is the second one or claims last early.
    assign cd_end   = cd_fire_o & (cd_last_i | beat_q);
    assign cd_bad_o = cd_fire_o & (cd_last_i ^ beat_q);

    assign target_o  = tgt_q;
    assign ac_done_o = ac_done_q;
    assign cr_done_o = cr_done_q;
    assign cd_pend_o = cd_pend_q;
    assign beat_o    = beat_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tgt_q     <= 1'b0;
            ac_done_q <= 1'b0;
            cr_done_q <= 1'b0;
            cd_pend_q <= 1'b0;
            beat_q    <= 1'b0;
        end else if (start_i) begin
            tgt_q     <= target_i;
            ac_done_q <= 1'b0;
            cr_done_q <= 1'b0;
            cd_pend_q <= 1'b0;
            beat_q    <= 1'b0;
        end else begin
            if (ac_valid_o & ac_ready_i) ac_done_q <= 1'b1;
            if (cr_fire_o | (timeout_i & tgt_q)) cr_done_q <= 1'b1;
            if (cr_fire_o & cr_dt_i) cd_pend_q <= 1'b1;
            else if (cd_end) cd_pend_q <= 1'b0;
            if (cd_fire_o) beat_q <= ~cd_end;
        end
    end

endmodule

// File: rtl/snoop_initiator.sv
// ACE snoop initiator: broadcast AC, merge CR, collect one CD line, return one response.
// Optional CR watchdog enabled by defining SNOOP_INITIATOR_TIMEOUT_EN.
module snoop_initiator
    import snoop_pkg::*;
#(
    parameter  int NumPorts      = 2,
    parameter  int TimeoutCycles = 1024,
    localparam int SrcW          = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  req_valid_i,
    output logic                                  req_ready_o,
    input  logic [63:0]                           req_addr_i,
    input  acsnoop_t                              req_snoop_i,
    input  logic [SrcW-1:0]                       req_src_i,
    output ariane_ace::snoop_req_t [NumPorts-1:0] snoop_req_o,
    input  ariane_ace::snoop_resp_t [NumPorts-1:0] snoop_resp_i,
    output logic                                  resp_valid_o,
    input  logic                                  resp_ready_i,
    output crresp_t                               resp_o,
    output logic [127:0]                          resp_data_o,
    output logic                                  busy_o
);

    snoop_init_state_t state_q, state_d;

    logic [63:0]     addr_q;
    acsnoop_t        snoop_q;
    crresp_t         resp_q, resp_d;
    logic [127:0]    data_q;
    logic [SrcW-1:0] dsrc_q;

    logic [NumPorts-1:0] tgt_mask, target, ac_valid, cr_ready, cd_ready;
    logic [NumPorts-1:0] ac_done, cr_done, cd_pend, cr_fire, cd_fire;
    logic [NumPorts-1:0] beat, cd_bad, pd_vec;
    logic start, timeout, ac_phase, cr_phase, cd_phase, pd_multi;
    crresp_t cr_or;

    assign tgt_mask = ~(NumPorts'(1) << req_src_i);
    assign ac_phase = (state_q == SEND_AC);
    assign cr_phase = (state_q == WAIT_CR);
    assign cd_phase = (state_q == RECV_CD);

    for (genvar i = 0; i < NumPorts; i++) begin : g_port
        snoop_port_tracker u_trk (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .start_i    (start),
            .target_i   (tgt_mask[i]),
            .ac_phase_i (ac_phase),
            .cr_phase_i (cr_phase),
            .cd_phase_i (cd_phase),
            .timeout_i  (timeout),
            .ac_ready_i (snoop_resp_i[i].ac_ready),
            .cr_valid_i (snoop_resp_i[i].cr_valid),
            .cr_dt_i    (snoop_resp_i[i].cr_resp.dataTransfer),
            .cd_valid_i (snoop_resp_i[i].cd_valid),
            .cd_last_i  (snoop_resp_i[i].cd.last),
            .target_o   (target[i]),
            .ac_valid_o (ac_valid[i]),
            .cr_ready_o (cr_ready[i]),
            .cd_ready_o (cd_ready[i]),
            .ac_done_o  (ac_done[i]),
            .cr_done_o  (cr_done[i]),
            .cd_pend_o  (cd_pend[i]),
            .cr_fire_o  (cr_fire[i]),
            .cd_fire_o  (cd_fire[i]),
            .beat_o     (beat[i]),
            .cd_bad_o   (cd_bad[i])
        );
    end

    always_comb begin
        snoop_req_o = '0;
        for (int i = 0; i < NumPorts; i++) begin
            snoop_req_o[i].ac_valid = ac_valid[i];
            snoop_req_o[i].ac.addr  = addr_q;
            snoop_req_o[i].ac.snoop = snoop_q;
            snoop_req_o[i].ac.prot  = '0;
            snoop_req_o[i].cr_ready = cr_ready[i];
            snoop_req_o[i].cd_ready = cd_ready[i];
        end
    end

`ifdef SNOOP_INITIATOR_TIMEOUT_EN
    localparam int CntW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
    logic [CntW-1:0] to_cnt_q;

    assign timeout = cr_phase && (cr_done != target) &&
                     (to_cnt_q == CntW'(TimeoutCycles - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            to_cnt_q <= '0;
        end else if (!cr_phase || (|cr_fire) || timeout) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Dirty data handed over by two owners is a coherence violation.
    always_comb begin
        cr_or  = '0;
        pd_vec = '0;
        for (int i = 0; i < NumPorts; i++) begin
            if (cr_fire[i]) cr_or = cr_or | (snoop_resp_i[i].cr_resp & CrMergeMask);
            pd_vec[i] = cr_fire[i] & snoop_resp_i[i].cr_resp.passDirty;
        end
        pd_multi = ((pd_vec & (pd_vec - 1'b1)) != '0) || (resp_q.passDirty && (|pd_vec));
        resp_d = resp_q | cr_or;
        if (pd_multi || timeout || (|cd_bad)) resp_d.error = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    start   = 1'b1;
                    state_d = (tgt_mask == '0) ? SEND_RESP : SEND_AC;
                end
            end
            SEND_AC: begin
                if (ac_done == target) state_d = WAIT_CR;
            end
            WAIT_CR: begin
                if (cr_done == target) state_d = (cd_pend != '0) ? RECV_CD : SEND_RESP;
            end
            RECV_CD: begin
                if (cd_pend == '0) state_d = SEND_RESP;
            end
            SEND_RESP: begin
                if (resp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            snoop_q <= '0;
            resp_q  <= '0;
            data_q  <= '0;
            dsrc_q  <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                addr_q  <= req_addr_i & ~64'hF;
                snoop_q <= req_snoop_i;
                resp_q  <= '0;
                data_q  <= '0;
            end else begin
                resp_q <= resp_d;
            end
            if (cr_phase && state_d == RECV_CD) begin
                dsrc_q <= SrcW'(lowest_set(MaxPorts'(cd_pend)));
            end
            if (cd_phase && cd_fire[dsrc_q]) begin
                if (beat[dsrc_q]) data_q[127:64] <= snoop_resp_i[dsrc_q].cd.data;
                else              data_q[63:0]   <= snoop_resp_i[dsrc_q].cd.data;
            end
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign busy_o       = (state_q != IDLE);
    assign resp_valid_o = (state_q == SEND_RESP);
    assign resp_o       = resp_q;
    assign resp_data_o  = resp_q.dataTransfer ? data_q : '0;

endmodule

// File: tb/tb_snoop_initiator.sv
// Randomized bench for snoop_initiator (3 ports) with a behavioural port/response model.
module tb_snoop_initiator;
    import snoop_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic req_valid, req_ready, resp_valid, resp_ready, busy;
    logic [63:0] req_addr;
    acsnoop_t req_snoop;
    logic [1:0] req_src;
    ariane_ace::snoop_req_t  [2:0] sreq;
    ariane_ace::snoop_resp_t [2:0] sresp;
    crresp_t resp;
    logic [127:0] rdata;

    snoop_initiator #(.NumPorts(3), .TimeoutCycles(16)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_snoop_i(req_snoop), .req_src_i(req_src),
        .snoop_req_o(sreq), .snoop_resp_i(sresp),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_o(resp), .resp_data_o(rdata), .busy_o(busy)
    );

    int n_vec = 0;
    int n_bad = 0;

    int ac_dly[3], cr_dly[3], cd_dly[3];
    crresp_t crr[3];
    logic [63:0] d0[3], d1[3];
    bit bad_last[3], no_cr[3];

    crresp_t got_resp;
    logic [127:0] got_data;
    int t_lastcr, t_respv;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic idle_drive();
        for (int p = 0; p < 3; p++) sresp[p] = '0;
        resp_ready = 1'b0;
    endtask

    task automatic clear_cfg();
        for (int p = 0; p < 3; p++) begin
            ac_dly[p] = 0; cr_dly[p] = 0; cd_dly[p] = 0;
            crr[p] = '0; d0[p] = '0; d1[p] = '0;
            bad_last[p] = 0; no_cr[p] = 0;
        end
    endtask

    task automatic check_reset(input string tag);
        #1;
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_resp_valid"}, resp_valid, 0);
        chk({tag, "_resp"}, resp, 0);
        chk({tag, "_data"}, rdata, 0);
        chk({tag, "_snoop_req"}, sreq, 0);
    endtask

    // Expected aggregate from the per-port answers, independent of timing.
    task automatic model(input logic [1:0] src, output crresp_t er, output logic [127:0] ed);
        int npd;
        bit found;
        npd = 0; found = 0; er = '0; ed = '0;
        for (int p = 0; p < 3; p++) begin
            if (p == int'(src)) continue;
            if (no_cr[p]) begin
                er.error = 1'b1;
                continue;
            end
            er.dataTransfer |= crr[p].dataTransfer;
            er.passDirty    |= crr[p].passDirty;
            er.isShared     |= crr[p].isShared;
            er.error        |= crr[p].error;
            if (crr[p].passDirty) npd++;
            if (crr[p].dataTransfer) begin
                if (bad_last[p]) er.error = 1'b1;
                if (!found) begin
                    found = 1;
                    ed = bad_last[p] ? {64'h0, d0[p]} : {d1[p], d0[p]};
                end
            end
        end
        if (npd > 1) er.error = 1'b1;
    endtask

    task automatic run_txn(input logic [63:0] addr, input acsnoop_t snp,
                           input logic [1:0] src, input int rdly, input bit hang);
        int ph[3];
        int cnt[3];
        int cyc, rcnt, limit;
        bit done, seen, any_nocr;
        crresp_t er, held_r;
        logic [127:0] ed, held_d;
        logic [63:0] ea;
        model(src, er, ed);
        ea = addr & ~64'hF;
        any_nocr = 0;
        for (int p = 0; p < 3; p++) begin
            ph[p] = (p == int'(src)) ? 6 : 0;
            cnt[p] = 0;
            if (p != int'(src) && no_cr[p]) any_nocr = 1;
        end
        @(negedge clk);
        req_valid = 1; req_addr = addr; req_snoop = snp; req_src = src;
        chk("req_ready", req_ready, 1);
        done = 0; seen = 0; rcnt = 0; cyc = 0; t_lastcr = 0; t_respv = 0;
        limit = hang ? 60 : 300;
        while (!done && cyc < limit) begin
            @(negedge clk);
            cyc++;
            req_valid = 0;
            idle_drive();
            if (hang) chk("busy_hang", busy, 1);
            for (int p = 0; p < 3; p++) begin
                chk($sformatf("ac_valid%0d", p), sreq[p].ac_valid, ph[p] == 0);
                if (sreq[p].ac_valid)
                    chk($sformatf("ac_payload%0d", p),
                        {sreq[p].ac.addr, sreq[p].ac.snoop, sreq[p].ac.prot},
                        {ea, snp, 3'b000});
                case (ph[p])
                    0: begin
                        if (cnt[p] >= ac_dly[p]) begin
                            sresp[p].ac_ready = 1;
                            if (sreq[p].ac_valid) begin ph[p] = 1; cnt[p] = 0; end
                        end else cnt[p]++;
                    end
                    1: begin
                        if (no_cr[p]) ph[p] = 5;
                        else if (cnt[p] >= cr_dly[p]) ph[p] = 2;
                        else cnt[p]++;
                    end
                    2: begin
                        sresp[p].cr_valid = 1;
                        sresp[p].cr_resp = crr[p];
                        if (sreq[p].cr_ready) begin
                            t_lastcr = cyc;
                            ph[p] = crr[p].dataTransfer ? 3 : 5;
                            cnt[p] = 0;
                        end
                    end
                    3: begin
                        if (cnt[p] < cd_dly[p]) cnt[p]++;
                        else begin
                            sresp[p].cd_valid = 1;
                            sresp[p].cd.data = d0[p];
                            sresp[p].cd.last = bad_last[p];
                            if (sreq[p].cd_ready) ph[p] = bad_last[p] ? 5 : 4;
                        end
                    end
                    4: begin
                        sresp[p].cd_valid = 1;
                        sresp[p].cd.data = d1[p];
                        sresp[p].cd.last = 1;
                        if (sreq[p].cd_ready) ph[p] = 5;
                    end
                    default: ;
                endcase
            end
            if (resp_valid) begin
                if (!seen) begin
                    seen = 1; t_respv = cyc;
                    held_r = resp; held_d = rdata;
                    got_resp = resp; got_data = rdata;
                    chk("resp", resp, er);
                    chk("resp_data", rdata, ed);
                    if (!er.dataTransfer && !any_nocr)
                        chk("miss_latency", t_respv - t_lastcr, 2);
                end else begin
                    chk("resp_hold", {resp, rdata}, {held_r, held_d});
                end
                if (rcnt >= rdly) begin resp_ready = 1; done = 1; end
                else rcnt++;
            end
        end
        if (!hang && !done) chk("txn_bound", 0, 1);
        if (done) begin
            @(negedge clk);
            idle_drive();
            chk("back_to_idle", {req_ready, busy, resp_valid}, 3'b100);
        end
    endtask

    initial begin
        acsnoop_t ops[5];
        crresp_t er_unused;
        ops[0] = READ_SHARED; ops[1] = READ_UNIQUE; ops[2] = CLEAN_INVALID;
        ops[3] = READ_ONCE; ops[4] = MAKE_INVALID;
        rst_n = 0; req_valid = 0; req_addr = '0; req_snoop = '0; req_src = '0;
        idle_drive();
        clear_cfg();
        repeat (3) @(negedge clk);
        check_reset("rst_hold");
        rst_n = 1;
        @(negedge clk);
        check_reset("rst_idle");

        // Port 1 supplies shared line; port 0 is the requester.
        clear_cfg();
        crr[1].dataTransfer = 1; crr[1].isShared = 1;
        d0[1] = 64'hA; d1[1] = 64'hB;
        run_txn(64'h8000_0040, READ_SHARED, 2'd0, 0, 0);
        chk("t1_resp", got_resp, 5'h09);
        chk("t1_data", got_data, {64'hB, 64'hA});

        // Two suppliers: lowest index wins, the other is drained.
        clear_cfg();
        crr[0].dataTransfer = 1; crr[1].dataTransfer = 1;
        d0[0] = 64'h11; d1[0] = 64'h12; d0[1] = 64'h21; d1[1] = 64'h22;
        cd_dly[0] = 2;
        run_txn(64'h1234_5678, CLEAN_INVALID, 2'd2, 1, 0);
        chk("t2_resp", got_resp, 5'h01);
        chk("t2_data", got_data, {64'h12, 64'h11});

        // All miss.
        clear_cfg();
        cr_dly[0] = 3;
        run_txn(64'hDEAD_BEEF, READ_ONCE, 2'd1, 0, 0);
        chk("t3_resp", got_resp, 0);
        chk("t3_data", got_data, 0);
        chk("t3_latency", t_respv - t_lastcr, 2);

        // Slow AC acceptance on port 1.
        clear_cfg();
        ac_dly[1] = 5;
        crr[1].dataTransfer = 1; d0[1] = 64'h55; d1[1] = 64'h66;
        run_txn(64'hCAFE_0000, READ_UNIQUE, 2'd0, 2, 0);
        chk("t4_data", got_data, {64'h66, 64'h55});

        // Early last on beat 0.
        clear_cfg();
        crr[1].dataTransfer = 1; bad_last[1] = 1; d0[1] = 64'h77;
        run_txn(64'h40, READ_SHARED, 2'd0, 0, 0);
        chk("t5_resp", got_resp, 5'h03);
        chk("t5_data", got_data, {64'h0, 64'h77});

        // Two dirty owners.
        clear_cfg();
        crr[0].dataTransfer = 1; crr[0].passDirty = 1;
        crr[1].dataTransfer = 1; crr[1].passDirty = 1;
        d0[0] = 64'h81; d1[0] = 64'h82; d0[1] = 64'h91; d1[1] = 64'h92;
        run_txn(64'h100, READ_UNIQUE, 2'd2, 0, 0);
        chk("t6_resp", got_resp, 5'h07);
        chk("t6_data", got_data, {64'h82, 64'h81});

        // Port 1 never answers CR.
        clear_cfg();
        no_cr[1] = 1;
`ifdef SNOOP_INITIATOR_TIMEOUT_EN
        run_txn(64'h200, READ_SHARED, 2'd0, 0, 0);
        chk("t7_timeout_err", got_resp.error, 1);
`else
        run_txn(64'h200, READ_SHARED, 2'd0, 0, 1);
        @(negedge clk);
        rst_n = 0; req_valid = 0;
        idle_drive();
        check_reset("rst_mid");
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check_reset("rst_after");
`endif
        clear_cfg();
        model(2'd0, er_unused, got_data);

        for (int t = 0; t < 40; t++) begin
            clear_cfg();
            for (int p = 0; p < 3; p++) begin
                ac_dly[p] = $urandom_range(0, 3);
                cr_dly[p] = $urandom_range(0, 4);
                cd_dly[p] = $urandom_range(0, 2);
                crr[p].dataTransfer = ($urandom_range(0, 1) == 1);
                crr[p].passDirty    = ($urandom_range(0, 3) == 0);
                crr[p].isShared     = ($urandom_range(0, 1) == 1);
                crr[p].error        = ($urandom_range(0, 9) == 0);
                crr[p].wasUnique    = ($urandom_range(0, 1) == 1);
                d0[p] = {$urandom, $urandom};
                d1[p] = {$urandom, $urandom};
                bad_last[p] = crr[p].dataTransfer && ($urandom_range(0, 9) == 0);
            end
            run_txn({$urandom, $urandom}, ops[$urandom_range(0, 4)],
                    2'($urandom_range(0, 2)), $urandom_range(0, 3), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
